// File: rtl/synfifo_pkg.sv
// Shared constants and helpers for the parametrised synfifo family.
package synfifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af,
                                     input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/synfifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module synfifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synfifo_flags.sv
// Single-clock FIFO with occupancy count, programmable thresholds,
// sticky error flags and optional first-word-fall-through read.
module synfifo_flags
    import synfifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wen,
    input  logic                      ren,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("synfifo_flags: DEPTH must be a power of two >= 2");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("synfifo_flags: AF_THRESH/AE_THRESH out of range");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("synfifo_flags: WIDTH must be >= 1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] mem_rd;

    // Wrap bit makes the modulo difference distinguish full from empty.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign rd_ok = ren && !empty;
    assign wr_ok = wen && (!full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wen && !wr_ok) begin
            ovf_d = 1'b1;
        end
        if (ren && !rd_ok) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    synfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_ok && rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rd)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata = mem_rd;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                rdata_q <= '0;
            end else if (rd_ok) begin
                rdata_q <= mem_rd;
            end
        end
        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_synfifo_flags.sv
// Directed bench: default 8x8 registered FIFO plus a 16x32 FWFT instance.
module tb_synfifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst0 = 1'b0, wen0 = 1'b0, ren0 = 1'b0, clr0 = 1'b0;
    logic [7:0] wd0 = '0;
    logic [7:0] rd0;
    logic [3:0] cnt0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;

    logic        rst1 = 1'b0, wen1 = 1'b0, ren1 = 1'b0, clr1 = 1'b0;
    logic [31:0] wd1 = '0;
    logic [31:0] rd1;
    logic [4:0]  cnt1;
    logic        full1, empty1, af1, ae1, ovf1, udf1;

    synfifo_flags dut0 (
        .clk(clk), .rst(rst0), .wen(wen0), .ren(ren0), .wdata(wd0),
        .err_clr(clr0), .rdata(rd0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    synfifo_flags #(
        .WIDTH(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .wen(wen1), .ren(ren1), .wdata(wd1),
        .err_clr(clr1), .rdata(rd1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  v;
        logic [31:0] w;

        // Reset state of both instances
        tick();
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_full", 32'(full0), 0);
        chk("rst_ae", 32'(ae0), 1);
        chk("rst_af", 32'(af0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_udf", 32'(udf0), 0);
        chk("rst_rdata", 32'(rd0), 0);
        chk("rst1_empty", 32'(empty1), 1);
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            wen0 = 1'b1;
            v = 8'(i * 8'h11);
            wd0 = v;
            tick();
            chk("fill_count", 32'(cnt0), 32'(i));
            chk("fill_af", 32'(af0), (i >= 6) ? 1 : 0);
            chk("fill_ae", 32'(ae0), (i <= 2) ? 1 : 0);
            chk("fill_full", 32'(full0), (i == 8) ? 1 : 0);
        end

        // Overflow on full, then clear
        wd0 = 8'hAA;
        tick();
        chk("ovf_set", 32'(ovf0), 1);
        chk("ovf_count", 32'(cnt0), 8);
        wen0 = 1'b0;
        clr0 = 1'b1;
        tick();
        chk("ovf_clr", 32'(ovf0), 0);
        clr0 = 1'b0;

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            ren0 = 1'b1;
            tick();
            chk("drain_rdata", 32'(rd0), 32'(i * 8'h11));
            chk("drain_count", 32'(cnt0), 32'(8 - i));
        end
        chk("drain_empty", 32'(empty0), 1);
        chk("drain_ae", 32'(ae0), 1);

        // Underflow on empty; rdata holds
        tick();
        chk("udf_set", 32'(udf0), 1);
        chk("udf_rdata", 32'(rd0), 32'h88);
        ren0 = 1'b0;
        clr0 = 1'b1;
        tick();
        chk("udf_clr", 32'(udf0), 0);
        clr0 = 1'b0;

        // Empty with wen and ren together
        wen0 = 1'b1;
        ren0 = 1'b1;
        wd0 = 8'h3C;
        tick();
        chk("ew_count", 32'(cnt0), 1);
        chk("ew_udf", 32'(udf0), 1);
        chk("ew_rdata", 32'(rd0), 32'h88);
        wen0 = 1'b0;
        tick();
        chk("ew_read", 32'(rd0), 32'h3C);
        chk("ew_empty", 32'(empty0), 1);
        ren0 = 1'b0;
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;

        // Simultaneous push/pop on full across three wrap rounds
        for (int r = 0; r < 3; r++) begin
            for (int j = 1; j <= 8; j++) begin
                wen0 = 1'b1;
                wd0 = 8'((r << 4) | j);
                tick();
            end
            chk("sim_full", 32'(full0), 1);
            ren0 = 1'b1;
            wd0 = 8'(8'hC0 | r);
            tick();
            chk("sim_count", 32'(cnt0), 8);
            chk("sim_head", 32'(rd0), 32'((r << 4) | 1));
            chk("sim_ovf", 32'(ovf0), 0);
            wen0 = 1'b0;
            for (int j = 2; j <= 9; j++) begin
                tick();
                v = (j == 9) ? 8'(8'hC0 | r) : 8'((r << 4) | j);
                chk("sim_drain", 32'(rd0), 32'(v));
            end
            ren0 = 1'b0;
            chk("sim_empty", 32'(empty0), 1);
        end

        // Reset mid-stream with a write pending
        for (int j = 0; j < 5; j++) begin
            wen0 = 1'b1;
            wd0 = 8'(j);
            tick();
        end
        chk("mid_count5", 32'(cnt0), 5);
        rst0 = 1'b0;
        tick();
        chk("mid_count", 32'(cnt0), 0);
        chk("mid_empty", 32'(empty0), 1);
        chk("mid_ae", 32'(ae0), 1);
        rst0 = 1'b1;
        wen0 = 1'b0;
        tick();
        chk("mid_after", 32'(cnt0), 0);
        chk("mid_ovf", 32'(ovf0), 0);

        // FWFT instance
        wen1 = 1'b1;
        wd1 = 32'hDEADBEEF;
        tick();
        wen1 = 1'b0;
        chk("fw_empty", 32'(empty1), 0);
        chk("fw_head", rd1, 32'hDEADBEEF);
        wen1 = 1'b1;
        wd1 = 32'h12345678;
        tick();
        wen1 = 1'b0;
        chk("fw_hold", rd1, 32'hDEADBEEF);
        chk("fw_count2", 32'(cnt1), 2);
        ren1 = 1'b1;
        tick();
        chk("fw_pop", rd1, 32'h12345678);
        chk("fw_count1", 32'(cnt1), 1);
        tick();
        ren1 = 1'b0;
        chk("fw_empty2", 32'(empty1), 1);
        for (int j = 0; j < 16; j++) begin
            wen1 = 1'b1;
            wd1 = 32'hA5000000 + 32'(j * 3);
            tick();
        end
        wen1 = 1'b0;
        chk("fw_full", 32'(full1), 1);
        chk("fw_count16", 32'(cnt1), 16);
        chk("fw_af", 32'(af1), 1);
        for (int j = 0; j < 16; j++) begin
            w = 32'hA5000000 + 32'(j * 3);
            chk("fw_drain", rd1, w);
            ren1 = 1'b1;
            tick();
        end
        ren1 = 1'b0;
        chk("fw_end_empty", 32'(empty1), 1);
        chk("fw_udf", 32'(udf1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synfifo_flags.md
Name: synfifo_flags

Overview:
Parametrised single-clock FIFO, successor to the existing 8x8 synfifo. Adds WIDTH/DEPTH generics, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. Used as the general buffering primitive between same-clock producer/consumer stages.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read data (1-cycle latency); 1 = head word visible on rdata while !empty

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
wen  in  1  write request
ren  in  1  read request
wdata  in  WIDTH  write data
err_clr  in  1  clears overflow/underflow (synchronous)
rdata  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write rejected since last clear
underflow  out  1  sticky: read rejected since last clear

Behaviour:
- Reset (rst==0 at clk edge): wr/rd pointers=0, count=0, rdata=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 impossible, so 0), overflow=0, underflow=0. Storage array not reset. Reset overrides wen/ren/err_clr in the same cycle; reset mid-stream discards all contents.
- Pointers: $clog2(DEPTH)+1 bits, MSB is wrap bit; address = low bits; count = wr_ptr - rd_ptr (modulo arithmetic). Natural wrap at DEPTH, no special case.
- Read accepted (rd_ok) = ren && !empty.
- Write accepted (wr_ok) = wen && (!full || rd_ok). Full with simultaneous accepted read: both proceed, count unchanged.
- Empty with wen&&ren: write accepted, read rejected (underflow set), count -> 1. No bypass of write data to rdata.
- count next = count + wr_ok - rd_ok.
- All status flags are decoded from registered state only (no combinational path from wen/ren to flags).
- FWFT=0: on rd_ok, rdata <= mem[rd_addr] at that edge (visible next cycle); otherwise rdata holds.
- FWFT=1: rdata = mem[rd_addr] combinationally; valid whenever empty==0; ren acknowledges/pops current word. When empty, rdata value is don't-care (bench must not check).
- overflow set on cycle with wen && !wr_ok; underflow set on ren && !rd_ok. Both hold until err_clr==1 or reset. Set has priority over err_clr in the same cycle.
- Rejected write does not modify storage or pointers; rejected read does not modify rdata or pointers.

Decomposition:
- Package synfifo_pkg: function ptr_w(depth) = $clog2(depth)+1; default WIDTH/DEPTH constants; elaboration-time parameter checks (DEPTH power of two, threshold ranges) as assertions.
- One sub-module: synfifo_mem, WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port; top selects registered vs. direct output per FWFT.

Test Plan:
- Fill/drain, defaults: reset, write 8 words 0x11..0x88 -> full=1 after 8th edge, count=8, almost_full from count 6; read 8 -> rdata 0x11..0x88 in order, one cycle after each ren; empty=1, count=0.
- Overflow: full FIFO, wen=1 with wdata=0xAA, ren=0 -> overflow=1, count stays 8, 0xAA never read; err_clr pulse -> overflow=0.
- Underflow: empty, ren=1 -> underflow=1, rdata unchanged (0 after reset); empty+wen+ren same cycle -> count=1, underflow=1, following read returns written word.
- Simultaneous on full: count=8, wen&ren with wdata=0x5C -> count=8, head popped, 0x5C emerges as 8th read after subsequent drain; pointer wrap exercised over 3 full cycles with no data corruption.
- FWFT=1, DEPTH=16, WIDTH=32: write 0xDEADBEEF to empty -> rdata=0xDEADBEEF the cycle after write with ren=0; ren pops, next word appears same cycle.
- Reset mid-operation: count=5, rst=0 for one edge with wen=1 -> count=0, empty=1, flags cleared, write ignored.
